// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
//   Shared types and line levels for the serial frame transmitter.
//   tx_state_t  : frame FSM states (IDLE, START, DATA, STOP)
//   LINE_IDLE   : level of the serial line between frames and during the stop bit
//   START_LEVEL : level of the start bit
package serial_tx_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Divides the clock into serial bit periods of DIV cycles.
//   clk     : system clock
//   clear_n : asynchronous active-low reset
//   run     : count while high; count is held at 0 while low
//   tick    : one-cycle pulse on the last cycle of each bit period
module bit_timer #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic clear_n,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // With DIV=1 the count is pinned at 0, so tick fires every running cycle.
   assign tick = run && (count == LAST);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (!run || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Parallel-in, serial-out frame transmitter: start bit, N data bits LSB first,
//   stop bit, each held for DIV clock cycles.
//   clk     : system clock
//   clear_n : asynchronous active-low reset
//   in      : parallel word, captured when load && ready at a posedge
//   load    : upstream request
//   ready   : high in IDLE, word can be accepted
//   busy    : high while a frame is in progress
//   tx      : registered serial line, idles high
//   done    : one-cycle pulse on the first IDLE cycle after a completed frame
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned DIV = 4
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic [N-1:0] in,
   input  logic         load,
   output logic         ready,
   output logic         busy,
   output logic         tx,
   output logic         done
);

   localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

   tx_state_t     state;
   logic [N-1:0]  shift;
   logic [N-1:0]  shift_nxt;
   logic [BW-1:0] bit_cnt;
   logic          tx_q;
   logic          done_q;
   logic          run;
   logic          tick;

   assign run       = (state != IDLE);
   assign shift_nxt = shift >> 1;

   bit_timer #(
      .DIV(DIV)
   ) u_timer (
      .clk     (clk),
      .clear_n (clear_n),
      .run     (run),
      .tick    (tick)
   );

   // tx is loaded with the level of the state being entered, so the line is
   // a pure register output and changes exactly on bit boundaries.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state   <= IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         tx_q    <= LINE_IDLE;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load) begin
                  state <= START;
                  shift <= in;
                  tx_q  <= START_LEVEL;
               end
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  tx_q  <= shift[0];
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= shift_nxt;
                  if (bit_cnt == LAST_BIT) begin
                     state   <= STOP;
                     bit_cnt <= '0;
                     tx_q    <= LINE_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_q    <= shift_nxt[0];
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  tx_q   <= LINE_IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);
   assign tx    = tx_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

   localparam int N   = 8;
   localparam int DIV = 4;
   localparam int L   = DIV * (N + 2);

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic [7:0] in0 = 8'h00;
   logic       load0 = 1'b0;
   logic       ready0, busy0, tx0, done0;
   logic [0:0] in1 = 1'b0;
   logic       load1 = 1'b0;
   logic       ready1, busy1, tx1, done1;

   always #5 clk = ~clk;

   serial_tx #(.N(8), .DIV(4)) u_dut (
      .clk     (clk),
      .clear_n (clear_n),
      .in      (in0),
      .load    (load0),
      .ready   (ready0),
      .busy    (busy0),
      .tx      (tx0),
      .done    (done0)
   );

   serial_tx #(.N(1), .DIV(1)) u_dut1 (
      .clk     (clk),
      .clear_n (clear_n),
      .in      (in1),
      .load    (load1),
      .ready   (ready1),
      .busy    (busy1),
      .tx      (tx1),
      .done    (done1)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] word;
      logic [9:0] line;   // expected line level per bit slot, slot 0 in bit 0
      bit         noise;  // hammer load with 8'hFF mid-frame
   } vec_t;

   vec_t vecs[6];

   // Reference model state for the randomized run.
   logic q[$];
   bit   m_ready;
   bit   m_last;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_frame(input logic [7:0] w, input logic [9:0] line, input bit noise,
                             input string tag);
      int guard = 0;
      while (!ready0 && guard < 200) begin
         step();
         guard++;
      end
      chk1({tag, " ready before load"}, ready0, 1'b1);
      in0   = w;
      load0 = 1'b1;
      step();
      load0 = 1'b0;
      in0   = 8'($urandom);
      for (int j = 0; j < L; j++) begin
         chk1($sformatf("%s tx slot %0d", tag, j), tx0, line[j / DIV]);
         chk1({tag, " busy"}, busy0, 1'b1);
         chk1({tag, " done low"}, done0, 1'b0);
         if (noise && j >= 8 && j < 16) begin
            load0 = 1'b1;
            in0   = 8'hFF;
         end else begin
            load0 = 1'b0;
         end
         step();
      end
      load0 = 1'b0;
      chk1({tag, " done pulse"}, done0, 1'b1);
      chk1({tag, " ready after"}, ready0, 1'b1);
      chk1({tag, " busy after"}, busy0, 1'b0);
      chk1({tag, " tx idle"}, tx0, 1'b1);
      step();
      chk1({tag, " done single"}, done0, 1'b0);
      step();
      chk1({tag, " no extra done"}, done0, 1'b0);
   endtask

   initial begin
      int cnt;
      int done_at;
      bit ld;
      logic [7:0] w;
      logic e_tx, e_ready, e_busy, e_done;

      vecs[0] = '{word: 8'hA5, line: 10'b1101001010, noise: 1'b0};
      vecs[1] = '{word: 8'h3C, line: 10'b1001111000, noise: 1'b1};
      vecs[2] = '{word: 8'h00, line: 10'b1000000000, noise: 1'b0};
      vecs[3] = '{word: 8'hFF, line: 10'b1111111110, noise: 1'b1};
      vecs[4] = '{word: 8'h5A, line: 10'b1010110100, noise: 1'b0};
      vecs[5] = '{word: 8'h81, line: 10'b1100000010, noise: 1'b0};

      // Reset held with load asserted: nothing may be accepted.
      clear_n = 1'b0;
      load0   = 1'b1;
      in0     = 8'hA5;
      load1   = 1'b1;
      in1     = 1'b1;
      repeat (3) begin
         step();
         chk1("rst tx", tx0, 1'b1);
         chk1("rst ready", ready0, 1'b1);
         chk1("rst busy", busy0, 1'b0);
         chk1("rst done", done0, 1'b0);
         chk1("rst ready1", ready1, 1'b1);
      end
      load0   = 1'b0;
      load1   = 1'b0;
      clear_n = 1'b1;
      step();
      chk1("post-rst idle", ready0, 1'b1);
      chk1("post-rst tx", tx0, 1'b1);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].word, vecs[v].line, vecs[v].noise, $sformatf("vec%0d", v));
      end

      // Back-to-back with load held high.
      in0   = 8'h00;
      load0 = 1'b1;
      step();
      in0     = 8'hFF;
      cnt     = 0;
      done_at = 0;
      while (cnt < 100) begin
         step();
         cnt++;
         if (done0) done_at = cnt;
         if (done_at > 0 && !ready0) break;
      end
      load0 = 1'b0;
      chk32("b2b done cycle", done_at, L);
      chk32("b2b accept spacing", cnt, L + 1);
      chk1("b2b second start", tx0, 1'b0);
      for (int j = 1; j < L; j++) begin
         step();
         chk1($sformatf("b2b FF slot %0d", j), tx0, vecs[3].line[j / DIV]);
      end
      step();
      chk1("b2b second done", done0, 1'b1);
      step();

      // Mid-frame reset during data bit 3 of 8'h5A.
      in0   = 8'h5A;
      load0 = 1'b1;
      step();
      load0 = 1'b0;
      repeat (DIV * 4 + 1) step();
      chk1("midrst busy before", busy0, 1'b1);
      #2;
      clear_n = 1'b0;
      #1;
      chk1("midrst async tx", tx0, 1'b1);
      chk1("midrst async ready", ready0, 1'b1);
      chk1("midrst async busy", busy0, 1'b0);
      chk1("midrst async done", done0, 1'b0);
      step();
      clear_n = 1'b1;
      cnt = 0;
      for (int j = 0; j < L + 4; j++) begin
         step();
         if (done0 || !ready0) cnt++;
      end
      chk32("midrst no done/no frame", cnt, 0);
      send_frame(8'h81, vecs[5].line, 1'b0, "after-rst");

      // DIV=1, N=1 corner: in=1 then in=0.
      for (int b = 1; b >= 0; b--) begin
         in1   = 1'(b);
         load1 = 1'b1;
         step();
         load1 = 1'b0;
         chk1("c1 start", tx1, 1'b0);
         chk1("c1 busy", busy1, 1'b1);
         step();
         chk1("c1 data", tx1, 1'(b));
         step();
         chk1("c1 stop", tx1, 1'b1);
         chk1("c1 no early done", done1, 1'b0);
         step();
         chk1("c1 done", done1, 1'b1);
         chk1("c1 ready", ready1, 1'b1);
         step();
         chk1("c1 done single", done1, 1'b0);
      end

      // Randomized run against a queue-based frame model.
      clear_n = 1'b0;
      step();
      clear_n = 1'b1;
      step();
      q.delete();
      m_ready = 1'b1;
      m_last  = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         load0 = ($urandom_range(0, 2) == 0);
         in0   = 8'($urandom);
         ld    = load0;
         w     = in0;
         step();
         if (ld && m_ready) begin
            for (int s = 0; s < N + 2; s++) begin
               logic lvl;
               if (s == 0) lvl = 1'b0;
               else if (s <= N) lvl = w[s - 1];
               else lvl = 1'b1;
               repeat (DIV) q.push_back(lvl);
            end
         end
         if (q.size() > 0) begin
            e_tx    = q.pop_front();
            e_ready = 1'b0;
            e_busy  = 1'b1;
            e_done  = 1'b0;
            m_last  = (q.size() == 0);
         end else begin
            e_tx    = 1'b1;
            e_ready = 1'b1;
            e_busy  = 1'b0;
            e_done  = m_last;
            m_last  = 1'b0;
         end
         m_ready = e_ready;
         chk1("rand tx", tx0, e_tx);
         chk1("rand ready", ready0, e_ready);
         chk1("rand busy", busy0, e_busy);
         chk1("rand done", done0, e_done);
      end
      load0 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
